// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM port arbiter.
//   arb_state_t : arbitration FSM state (free arbitration or locked to one requester)
//   req_id_t    : requester identifier, 0 = m0 (fetch), 1 = m1 (load/store)
//   rd_tag_t    : per-read tracking tag carried alongside the RAM read latency
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t ID_M0 = 1'b0;
  localparam req_id_t ID_M1 = 1'b1;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift register of read tags that mirrors the RAM read latency so the
// returning data can be steered to the requester that issued the read.
//   clk  : clock
//   clr  : synchronous clear of every stage
//   din  : tag for the access issued this cycle
//   dout : tag whose read data is on the RAM output this cycle
module rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    clr,
  input  rd_tag_t din,
  output rd_tag_t dout
);

  rd_tag_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between m0 (fetch) and m1 (LSU).
// Round-robin grant with a lock for atomic read-modify-write; read data is
// routed back to the issuing requester after RD_LATENCY cycles.
//   clk, rst                : clock, synchronous active-high reset
//   mX_req/we/lock/addr/wdata: requester X access (held until granted)
//   mX_gnt                  : combinational accept of requester X
//   mX_rvalid/rdata         : read return for requester X
//   mem_en/we/addr/wdata    : RAM command, muxed from the granted requester
//   mem_rdata               : RAM read data
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_t state_q, state_d;
  req_id_t    last_gnt_q, last_gnt_d;
  rd_tag_t    tag_in, tag_out;
  logic       xfer;
  logic       xfer_lock;
  req_id_t    gnt_id;

  // State and round-robin pointer; reset points at m1 so m0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      last_gnt_q <= ID_M1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Grant, next state and RAM command mux.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    xfer       = 1'b0;
    xfer_lock  = 1'b0;
    gnt_id     = ID_M0;

    if (!rst) begin
      unique case (state_q)
        ARB: begin
          if (m0_req && m1_req) begin
            m0_gnt = (last_gnt_q == ID_M1);
            m1_gnt = (last_gnt_q == ID_M0);
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
        LOCK0:   m0_gnt = m0_req;
        LOCK1:   m1_gnt = m1_req;
        default: ;
      endcase
    end

    if (m0_gnt) begin
      xfer      = 1'b1;
      xfer_lock = m0_lock;
      gnt_id    = ID_M0;
      mem_en    = 1'b1;
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      xfer      = 1'b1;
      xfer_lock = m1_lock;
      gnt_id    = ID_M1;
      mem_en    = 1'b1;
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end

    // Only a transfer moves the FSM: its lock bit selects hold or release.
    if (xfer) begin
      last_gnt_d = gnt_id;
      if (xfer_lock) state_d = (gnt_id == ID_M1) ? LOCK1 : LOCK0;
      else           state_d = ARB;
    end

    tag_in.valid = xfer && !mem_we;
    tag_in.id    = gnt_id;
  end

  rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk  (clk),
    .clr  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign m0_rvalid = tag_out.valid && (tag_out.id == ID_M0);
  assign m1_rvalid = tag_out.valid && (tag_out.id == ID_M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: three arbiter instances (RD_LATENCY 1, 2, 3) share one
// stimulus stream, each with its own RAM model of matching read latency.
module tb_ram_port_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst;
  logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  logic [2:0]         gnt0, gnt1, rv0, rv1, men, mwe;
  logic [2:0][DW-1:0] rd0, rd1, mwdata;
  logic [2:0][AW-1:0] maddr;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = g + 1;
    logic [DW-1:0] ram   [256];
    logic [DW-1:0] rpipe [3];
    logic [DW-1:0] mrd;

    // RAM model: LAT-cycle read latency, garbage on the bus when not reading.
    always_ff @(posedge clk) begin
      if (ld_en) ram[ld_addr] <= ld_data;
      else if (men[g] && mwe[g]) ram[maddr[g]] <= mwdata[g];
      rpipe[0] <= (men[g] && !mwe[g]) ? ram[maddr[g]] : 32'hBAD0_0000;
      rpipe[1] <= rpipe[0];
      rpipe[2] <= rpipe[1];
    end
    assign mrd = rpipe[LAT-1];

    ram_port_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RD_LATENCY (LAT)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_lock   (m0_lock),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (gnt0[g]),
      .m0_rvalid (rv0[g]),
      .m0_rdata  (rd0[g]),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_lock   (m1_lock),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (gnt1[g]),
      .m1_rvalid (rv1[g]),
      .m1_rdata  (rd1[g]),
      .mem_en    (men[g]),
      .mem_we    (mwe[g]),
      .mem_addr  (maddr[g]),
      .mem_wdata (mwdata[g]),
      .mem_rdata (mrd)
    );
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling mid-cycle.
  task automatic settle();
    #3;
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    cyc();
    ld_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    idle();
    rst = 1'b1;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  task automatic rd0_req(input logic [AW-1:0] a);
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = a;
  endtask

  task automatic rd1_req(input logic [AW-1:0] a);
    m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = a;
  endtask

  task automatic wr1_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
    m1_req = 1'b1; m1_we = 1'b1; m1_lock = lk; m1_addr = a; m1_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    idle();
    rst = 1'b1;
    cyc();
    load(8'h10, 32'hDEAD_BEEF);
    for (int a = 1; a <= 4; a++) load(AW'(a), 32'h1111_1111 * 32'(a));
    cyc();

    // Grants are suppressed while reset is held.
    rd0_req(8'h01);
    settle();
    expect_eq("rst_gnt0", 32'(gnt0[0]), 32'd0);
    expect_eq("rst_men", 32'(men[0]), 32'd0);
    cyc();
    idle();
    rst = 1'b0;
    settle();
    expect_eq("reset_rv0", 32'(rv0[0]), 32'd0);
    expect_eq("reset_rv1", 32'(rv1[0]), 32'd0);
    expect_eq("idle_men", 32'(men[0]), 32'd0);
    expect_eq("idle_maddr", 32'(maddr[0]), 32'd0);
    cyc();

    // Single read, observed at each latency.
    rd0_req(8'h10);
    settle();
    expect_eq("single_gnt0", 32'(gnt0[0]), 32'd1);
    expect_eq("single_gnt1", 32'(gnt1[0]), 32'd0);
    expect_eq("single_men", 32'(men[0]), 32'd1);
    expect_eq("single_mwe", 32'(mwe[0]), 32'd0);
    expect_eq("single_maddr", 32'(maddr[0]), 32'h10);
    cyc();
    idle();
    settle();
    expect_eq("single_rv0_l1", 32'(rv0[0]), 32'd1);
    expect_eq("single_rd0_l1", rd0[0], 32'hDEAD_BEEF);
    expect_eq("single_rv1_l1", 32'(rv1[0]), 32'd0);
    expect_eq("single_rv0_l2_early", 32'(rv0[1]), 32'd0);
    cyc();
    settle();
    expect_eq("single_rv0_l2", 32'(rv0[1]), 32'd1);
    expect_eq("single_rd0_l2", rd0[1], 32'hDEAD_BEEF);
    expect_eq("single_rv0_l1_drop", 32'(rv0[0]), 32'd0);
    expect_eq("single_rd0_l1_zero", rd0[0], 32'd0);
    cyc();
    settle();
    expect_eq("single_rv0_l3", 32'(rv0[2]), 32'd1);
    expect_eq("single_rd0_l3", rd0[2], 32'hDEAD_BEEF);
    cyc();

    // Continuous conflict from reset: m0, m1, m0, m1.
    do_reset(2);
    for (int k = 0; k < 5; k++) begin
      idle();
      if (k < 4) begin
        rd0_req(8'h01);
        rd1_req(8'h02);
      end
      settle();
      if (k < 4) begin
        expect_eq($sformatf("rr_gnt0_%0d", k), 32'(gnt0[0]), 32'((k % 2) == 0));
        expect_eq($sformatf("rr_gnt1_%0d", k), 32'(gnt1[0]), 32'((k % 2) == 1));
      end
      if (k > 0) begin
        expect_eq($sformatf("rr_rv0_%0d", k), 32'(rv0[0]), 32'(((k - 1) % 2) == 0));
        expect_eq($sformatf("rr_rv1_%0d", k), 32'(rv1[0]), 32'(((k - 1) % 2) == 1));
        if (((k - 1) % 2) == 0) expect_eq($sformatf("rr_rd0_%0d", k), rd0[0], 32'h1111_1111);
        else                    expect_eq($sformatf("rr_rd1_%0d", k), rd1[0], 32'h2222_2222);
      end
      cyc();
    end

    // m1 locks the port across writes; m0 waits until the unlocking transfer.
    idle();
    wr1_req(8'h20, 32'h0000_00A5, 1'b1);
    settle();
    expect_eq("lock_c0_gnt1", 32'(gnt1[0]), 32'd1);
    expect_eq("lock_c0_mwe", 32'(mwe[0]), 32'd1);
    expect_eq("lock_c0_maddr", 32'(maddr[0]), 32'h20);
    expect_eq("lock_c0_mwdata", mwdata[0], 32'h0000_00A5);
    cyc();
    rd0_req(8'h03);
    wr1_req(8'h21, 32'h0000_00A6, 1'b1);
    settle();
    expect_eq("lock_c1_gnt0", 32'(gnt0[0]), 32'd0);
    expect_eq("lock_c1_gnt1", 32'(gnt1[0]), 32'd1);
    expect_eq("lock_c1_rv1", 32'(rv1[0]), 32'd0);
    cyc();
    m1_req = 1'b0;
    settle();
    expect_eq("lock_c2_gnt0", 32'(gnt0[0]), 32'd0);
    expect_eq("lock_c2_men", 32'(men[0]), 32'd0);
    cyc();
    wr1_req(8'h22, 32'h0000_00A7, 1'b0);
    settle();
    expect_eq("lock_c3_gnt0", 32'(gnt0[0]), 32'd0);
    expect_eq("lock_c3_gnt1", 32'(gnt1[0]), 32'd1);
    cyc();
    m1_req = 1'b0; m1_lock = 1'b0;
    settle();
    expect_eq("lock_c4_gnt0", 32'(gnt0[0]), 32'd1);
    expect_eq("lock_c4_maddr", 32'(maddr[0]), 32'h03);
    cyc();
    idle();
    settle();
    expect_eq("lock_c5_rv0", 32'(rv0[0]), 32'd1);
    expect_eq("lock_c5_rd0", rd0[0], 32'h3333_3333);
    cyc();
    repeat (3) cyc();

    // Reset while a read is in flight; first conflict afterwards goes to m0.
    rd0_req(8'h10);
    settle();
    expect_eq("rstmid_gnt0", 32'(gnt0[1]), 32'd1);
    cyc();
    rst = 1'b1;
    rd0_req(8'h01);
    rd1_req(8'h02);
    settle();
    expect_eq("rstmid_gnt0_forced", 32'(gnt0[1]), 32'd0);
    expect_eq("rstmid_gnt1_forced", 32'(gnt1[1]), 32'd0);
    expect_eq("rstmid_men_forced", 32'(men[1]), 32'd0);
    cyc();
    rst = 1'b0;
    settle();
    expect_eq("rstmid_rv0_l2_dropped", 32'(rv0[1]), 32'd0);
    expect_eq("rstmid_rv1_l2", 32'(rv1[1]), 32'd0);
    expect_eq("rstmid_first_gnt0", 32'(gnt0[1]), 32'd1);
    expect_eq("rstmid_first_gnt1", 32'(gnt1[1]), 32'd0);
    cyc();
    idle();
    settle();
    expect_eq("rstmid_rv0_l3_dropped", 32'(rv0[2]), 32'd0);
    expect_eq("rstmid_rv0_l2_wait", 32'(rv0[1]), 32'd0);
    cyc();
    settle();
    expect_eq("rstmid_rv0_l2_new", 32'(rv0[1]), 32'd1);
    expect_eq("rstmid_rd0_l2_new", rd0[1], 32'h1111_1111);
    cyc();
    repeat (3) cyc();

    // Interleaved reads of 0x01..0x04 through the 3-cycle latency instance.
    for (int k = 0; k < 8; k++) begin
      idle();
      if (k < 4) begin
        if ((k % 2) == 0) rd0_req(AW'(k + 1));
        else              rd1_req(AW'(k + 1));
      end
      settle();
      if (k < 4) begin
        expect_eq($sformatf("lat3_gnt0_%0d", k), 32'(gnt0[2]), 32'((k % 2) == 0));
        expect_eq($sformatf("lat3_gnt1_%0d", k), 32'(gnt1[2]), 32'((k % 2) == 1));
      end
      if (k < 3) begin
        expect_eq($sformatf("lat3_early_%0d", k), 32'(rv0[2] | rv1[2]), 32'd0);
      end else begin
        expect_eq($sformatf("lat3_rv0_%0d", k), 32'(rv0[2]), 32'((k - 3) < 4 && ((k - 3) % 2) == 0));
        expect_eq($sformatf("lat3_rv1_%0d", k), 32'(rv1[2]), 32'((k - 3) < 4 && ((k - 3) % 2) == 1));
        if ((k - 3) < 4) begin
          if (((k - 3) % 2) == 0) expect_eq($sformatf("lat3_rd0_%0d", k), rd0[2], 32'h1111_1111 * 32'(k - 2));
          else                    expect_eq($sformatf("lat3_rd1_%0d", k), rd1[2], 32'h1111_1111 * 32'(k - 2));
        end
      end
      cyc();
    end

    // Write then read of the same address on consecutive cycles.
    idle();
    wr1_req(8'h04, 32'h0000_0055, 1'b0);
    settle();
    expect_eq("wr_gnt1", 32'(gnt1[0]), 32'd1);
    cyc();
    idle();
    rd0_req(8'h04);
    settle();
    expect_eq("wr_no_rv1", 32'(rv1[0]), 32'd0);
    expect_eq("wr_no_rv0", 32'(rv0[0]), 32'd0);
    expect_eq("rd_gnt0", 32'(gnt0[0]), 32'd1);
    cyc();
    idle();
    settle();
    expect_eq("wr_rd_rv0", 32'(rv0[0]), 32'd1);
    expect_eq("wr_rd_rd0", rd0[0], 32'h0000_0055);
    expect_eq("wr_rd_rv1", 32'(rv1[0]), 32'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
